// File: rtl/drum_note_scroller.sv
// Note track scroller and hit judge for the drum game: scrolls pattern rows toward the hit row
// on each tempo tick, scores pad presses and gates the tempo generator. Option: COMBO_BONUS_EN.
module drum_note_scroller #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 16,
  parameter int SONG_LEN = 256,
  parameter int SCORE_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     tick,
  input  logic [LANES-1:0]         pads,
  input  logic [LANES-1:0]         pat_data,
  output logic [7:0]               pat_addr,
  output logic                     stop,
  output logic [DEPTH*LANES-1:0]   track,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       misses,
  output logic [7:0]               combo,
  output logic                     hit_pulse,
  output logic                     miss_pulse,
  output logic                     playing,
  output logic                     done
);
  // state  | meaning
  // S_IDLE | after reset, tempo held stopped
  // S_PLAY | song running, ticks scroll the track
  // S_DONE | song and flush finished, score held
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;

  localparam int CW = $clog2(LANES + 1);
  localparam int LW = $clog2(SONG_LEN + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LOAD_END   = LW'(SONG_LEN);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(DEPTH - 1);

  function automatic logic [CW-1:0] popcnt(input logic [LANES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  state_t                   r_state, w_next_state;
  logic [DEPTH*LANES-1:0]   r_track;
  logic [SCORE_W-1:0]       r_score, r_misses;
  logic [7:0]               r_combo, r_pat_addr;
  logic [LW-1:0]            r_load_cnt;
  logic [FW-1:0]            r_flush_cnt;
  logic [LANES-1:0]         r_pads_q;
  logic                     r_stop, r_hit_pulse, r_miss_pulse;

  logic [LANES-1:0] w_press, w_row0, w_hits, w_wrong, w_row0_left, w_top_row;
  logic [CW-1:0]    w_nhits, w_nmiss;
  logic [CW:0]      w_pts;
  logic [SCORE_W:0] w_score_sum, w_miss_sum;
  logic [8:0]       w_combo_sum;
  logic             w_loads_done, w_scroll_miss;

  assign w_press      = pads & ~r_pads_q;
  assign w_row0       = r_track[LANES-1:0];
  assign w_hits       = w_press & w_row0;
  assign w_wrong      = w_press & ~w_row0;
  // Notes hit this cycle leave row 0 before any scroll, so they can never count as misses.
  assign w_row0_left  = w_row0 & ~w_hits;
  assign w_nhits      = popcnt(w_hits);
  assign w_nmiss      = popcnt(w_row0_left);
  assign w_loads_done = (r_load_cnt == LOAD_END);
  assign w_top_row    = w_loads_done ? '0 : pat_data;
  assign w_scroll_miss = tick && (|w_row0_left);

`ifdef COMBO_BONUS_EN
  assign w_pts = (r_combo >= 8'd8) ? {w_nhits, 1'b0} : {1'b0, w_nhits};
`else
  assign w_pts = {1'b0, w_nhits};
`endif

  assign w_score_sum = {1'b0, r_score} + (SCORE_W+1)'(w_pts);
  assign w_miss_sum  = {1'b0, r_misses} + (SCORE_W+1)'(w_nmiss);
  assign w_combo_sum = {1'b0, r_combo} + 9'(w_nhits);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_PLAY;
      S_PLAY:  if (tick && w_loads_done && r_flush_cnt == FLUSH_LAST) w_next_state = S_DONE;
      S_DONE:  if (start) w_next_state = S_PLAY;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_track      <= '0;
      r_score      <= '0;
      r_misses     <= '0;
      r_combo      <= '0;
      r_pat_addr   <= '0;
      r_load_cnt   <= '0;
      r_flush_cnt  <= '0;
      r_pads_q     <= '0;
      r_stop       <= 1'b1;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
    end else begin
      r_pads_q     <= pads;
      r_stop       <= (r_state != S_PLAY);
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      if (r_state != S_PLAY) begin
        if (start) begin
          r_track     <= '0;
          r_score     <= '0;
          r_misses    <= '0;
          r_combo     <= '0;
          r_pat_addr  <= '0;
          r_load_cnt  <= '0;
          r_flush_cnt <= '0;
        end
      end else begin
        r_hit_pulse <= |w_hits;
        r_score     <= w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
        if ((|w_wrong) || w_scroll_miss) r_combo <= '0;
        else                             r_combo <= w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
        if (tick) begin
          r_track      <= {w_top_row, r_track[DEPTH*LANES-1:LANES]};
          r_misses     <= w_miss_sum[SCORE_W] ? '1 : w_miss_sum[SCORE_W-1:0];
          r_miss_pulse <= |w_row0_left;
          if (w_loads_done) begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
          end else begin
            r_load_cnt <= r_load_cnt + LW'(1);
            r_pat_addr <= r_pat_addr + 8'd1;
          end
        end else begin
          r_track[LANES-1:0] <= w_row0_left;
        end
      end
    end
  end

  assign pat_addr   = r_pat_addr;
  assign stop       = r_stop;
  assign track      = r_track;
  assign score      = r_score;
  assign misses     = r_misses;
  assign combo      = r_combo;
  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;
  assign playing    = (r_state == S_PLAY);
  assign done       = (r_state == S_DONE);
endmodule

// File: tb/tb_drum_note_scroller.sv
// Bench for drum_note_scroller: directed song scenarios plus randomized play checked against
// a row-array model of the game rules. Small SONG_LEN/SCORE_W so flush and saturation are reached.
module tb_drum_note_scroller;
  localparam int L    = 4;
  localparam int D    = 16;
  localparam int SL   = 24;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk, rst_n, start, tick;
  logic [L-1:0] pads, pat_data;
  logic [7:0] pat_addr, combo;
  logic stop, hit_pulse, miss_pulse, playing, done;
  logic [D*L-1:0] track;
  logic [SW-1:0] score, misses;

  logic [L-1:0] pattern [256];
  assign pat_data = pattern[pat_addr];

  drum_note_scroller #(.LANES(L), .DEPTH(D), .SONG_LEN(SL), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .pads(pads), .pat_data(pat_data),
    .pat_addr(pat_addr), .stop(stop), .track(track), .score(score), .misses(misses),
    .combo(combo), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .playing(playing), .done(done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 play, 2 done
  int m_mode, m_loaded, m_flushed, m_score, m_misses, m_combo, m_addr;
  logic [L-1:0] m_rows [D];
  logic [L-1:0] m_pads_q;
  logic m_hitp, m_missp, m_stop;

  task automatic model_reset();
    m_mode = 0; m_loaded = 0; m_flushed = 0; m_score = 0; m_misses = 0; m_combo = 0;
    m_addr = 0; m_pads_q = '0; m_hitp = 0; m_missp = 0; m_stop = 1;
    for (int r = 0; r < D; r++) m_rows[r] = '0;
  endtask

  task automatic model_clear_song();
    m_loaded = 0; m_flushed = 0; m_score = 0; m_misses = 0; m_combo = 0; m_addr = 0;
    for (int r = 0; r < D; r++) m_rows[r] = '0;
  endtask

  function automatic logic [D*L-1:0] m_pack();
    logic [D*L-1:0] v;
    for (int r = 0; r < D; r++) v[r*L +: L] = m_rows[r];
    return v;
  endfunction

  task automatic model_step(input logic st, input logic tk, input logic [L-1:0] pd);
    logic [L-1:0] press, hits, wrong;
    int nh, pts, nm;
    logic next_stop;
    press = pd & ~m_pads_q;
    m_pads_q = pd;
    m_hitp = 0; m_missp = 0;
    next_stop = (m_mode != 1);
    if (m_mode == 1) begin
      hits = press & m_rows[0];
      wrong = press & ~m_rows[0];
      m_rows[0] = m_rows[0] & ~hits;
      nh = $countones(hits);
      pts = nh;
`ifdef COMBO_BONUS_EN
      if (m_combo >= 8) pts = 2 * nh;
`endif
      m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
      if (wrong != 0) m_combo = 0;
      else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
      m_hitp = (nh > 0);
      if (tk) begin
        nm = $countones(m_rows[0]);
        if (nm > 0) begin
          m_misses = (m_misses + nm > SMAX) ? SMAX : m_misses + nm;
          m_combo = 0;
          m_missp = 1;
        end
        for (int r = 0; r < D - 1; r++) m_rows[r] = m_rows[r+1];
        if (m_loaded < SL) begin
          m_rows[D-1] = pattern[m_loaded];
          m_loaded++;
          m_addr = (m_addr + 1) % 256;
        end else begin
          m_rows[D-1] = '0;
          m_flushed++;
          if (m_flushed == D) m_mode = 2;
        end
      end
    end else if (st) begin
      m_mode = 1;
      model_clear_song();
    end
    m_stop = next_stop;
  endtask

  task automatic cycle(input logic st, input logic tk, input logic [L-1:0] pd);
    @(negedge clk);
    start = st; tick = tk; pads = pd;
    model_step(st, tk, pd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++;
    if ({stop, playing, done, hit_pulse, miss_pulse} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags got %b exp 10000", {stop, playing, done, hit_pulse, miss_pulse});
    end
    checks++;
    if ({track, score, misses, combo, pat_addr} !== '0) begin
      errors++; $display("FAIL reset_regs got track %h score %0d misses %0d combo %0d addr %0d exp all 0",
                         track, score, misses, combo, pat_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 4'b0000);
      cycle(0, 0, 4'b0000);
    end
    checks++;
    if ({track, score, pat_addr, stop, playing} !== {{(D*L){1'b0}}, 4'd0, 8'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL idle_ticks got track %h score %0d addr %0d stop %b playing %b exp 0 0 0 1 0",
                         track, score, pat_addr, stop, playing);
    end
  endtask

  task automatic test_scroll_load();
    cycle(1, 0, 4'b0000);
    checks++;
    if ({playing, stop} !== 2'b11) begin
      errors++; $display("FAIL start_enter got playing,stop %b exp 11", {playing, stop});
    end
    cycle(0, 0, 4'b0000);
    checks++;
    if (stop !== 1'b0) begin errors++; $display("FAIL stop_lag got %b exp 0", stop); end
    cycle(0, 1, 4'b0000);
    checks++;
    if ({track[(D-1)*L +: L], pat_addr} !== {4'b0001, 8'd1}) begin
      errors++; $display("FAIL first_load got row_top %b addr %0d exp 0001 1", track[(D-1)*L +: L], pat_addr);
    end
    cycle(0, 0, 4'b0000);
    for (int i = 0; i < D - 1; i++) begin
      cycle(0, 1, 4'b0000);
      cycle(0, 0, 4'b0000);
    end
    checks++;
    if ({track[L-1:0], pat_addr, misses} !== {4'b0001, 8'd16, 4'd0}) begin
      errors++; $display("FAIL note_at_row0 got row0 %b addr %0d misses %0d exp 0001 16 0",
                         track[L-1:0], pat_addr, misses);
    end
  endtask

  task automatic test_hit();
    cycle(0, 0, 4'b0001);
    checks++;
    if ({score, combo, hit_pulse, track[L-1:0]} !== {4'd1, 8'd1, 1'b1, 4'b0000}) begin
      errors++; $display("FAIL hit got score %0d combo %0d hit_pulse %b row0 %b exp 1 1 1 0000",
                         score, combo, hit_pulse, track[L-1:0]);
    end
    cycle(0, 0, 4'b0000);
    checks++;
    if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_width got %b exp 0", hit_pulse); end
    cycle(0, 1, 4'b0000);
    checks++;
    if ({misses, miss_pulse, track[L-1:0]} !== {4'd0, 1'b0, 4'b0001}) begin
      errors++; $display("FAIL after_hit_tick got misses %0d miss_pulse %b row0 %b exp 0 0 0001",
                         misses, miss_pulse, track[L-1:0]);
    end
  endtask

  task automatic test_miss_wrong();
    cycle(0, 0, 4'b0000);
    cycle(0, 1, 4'b0000);
    checks++;
    if ({misses, combo, miss_pulse} !== {4'd1, 8'd0, 1'b1}) begin
      errors++; $display("FAIL miss got misses %0d combo %0d miss_pulse %b exp 1 0 1", misses, combo, miss_pulse);
    end
    cycle(0, 0, 4'b0010);
    checks++;
    if ({score, combo} !== {4'd2, 8'd1}) begin
      errors++; $display("FAIL rehit got score %0d combo %0d exp 2 1", score, combo);
    end
    cycle(0, 0, 4'b0001);
    checks++;
    if ({score, combo, hit_pulse} !== {4'd2, 8'd0, 1'b0}) begin
      errors++; $display("FAIL wrong_press got score %0d combo %0d hit_pulse %b exp 2 0 0", score, combo, hit_pulse);
    end
    cycle(0, 0, 4'b0000);
    cycle(0, 1, 4'b0000);
  endtask

  task automatic test_simultaneous();
    checks++;
    if (track[L-1:0] !== 4'b1010) begin errors++; $display("FAIL multi_setup got row0 %b exp 1010", track[L-1:0]); end
    cycle(0, 1, 4'b1010);
    checks++;
    if ({score, misses, combo, hit_pulse, miss_pulse} !== {4'd4, 4'd1, 8'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL tick_and_press got score %0d misses %0d combo %0d hp %b mp %b exp 4 1 2 1 0",
                         score, misses, combo, hit_pulse, miss_pulse);
    end
    cycle(0, 0, 4'b0000);
  endtask

  task automatic test_random_play(input int budget);
    int n;
    logic [L-1:0] pd;
    n = 0;
    while (m_mode != 2 && n < budget) begin
      pd = L'($urandom_range(0, 15) & $urandom_range(0, 15));
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0), pd);
      n++;
      checks++;
      if (track !== m_pack()) begin
        errors++; $display("FAIL rand_track cyc %0d got %h exp %h", n, track, m_pack());
      end
      checks++;
      if ({score, misses, combo, pat_addr} !== {SW'(m_score), SW'(m_misses), 8'(m_combo), 8'(m_addr)}) begin
        errors++; $display("FAIL rand_counts cyc %0d got score %0d misses %0d combo %0d addr %0d exp %0d %0d %0d %0d",
                           n, score, misses, combo, pat_addr, m_score, m_misses, m_combo, m_addr);
      end
      checks++;
      if ({hit_pulse, miss_pulse, stop, playing, done} !== {m_hitp, m_missp, m_stop, m_mode == 1, m_mode == 2}) begin
        errors++; $display("FAIL rand_flags cyc %0d got %b exp %b", n,
                           {hit_pulse, miss_pulse, stop, playing, done}, {m_hitp, m_missp, m_stop, m_mode == 1, m_mode == 2});
      end
    end
    checks++;
    if (m_mode != 2 || done !== 1'b1) begin
      errors++; $display("FAIL song_end_timeout got done %b after %0d cycles exp 1", done, n);
    end
  endtask

  task automatic test_end_of_song();
    logic [D*L-1:0] t0;
    logic [SW-1:0] s0;
    cycle(0, 0, 4'b0000);
    checks++;
    if ({done, stop, playing} !== 3'b110) begin
      errors++; $display("FAIL done_stop got done,stop,playing %b exp 110", {done, stop, playing});
    end
    t0 = track; s0 = score;
    cycle(0, 1, 4'b1111);
    cycle(0, 1, 4'b0000);
    checks++;
    if ({track, score, done, hit_pulse, miss_pulse} !== {t0, s0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL done_ignores got track %h score %0d done %b exp %h %0d 1", track, score, done, t0, s0);
    end
    for (int i = 0; i < SL; i++) pattern[i] = 4'b0001;
    cycle(1, 0, 4'b0000);
    checks++;
    if ({playing, done, score, misses, combo, pat_addr, track} !== {1'b1, 1'b0, {(SW*2+16+D*L){1'b0}}}) begin
      errors++; $display("FAIL restart got playing %b done %b score %0d misses %0d combo %0d addr %0d exp 1 0 0 0 0 0",
                         playing, done, score, misses, combo, pat_addr);
    end
  endtask

  task automatic test_combo_bonus();
    int exp_score;
    cycle(0, 0, 4'b0000);
    for (int i = 0; i < D; i++) begin
      cycle(0, 1, 4'b0000);
      cycle(0, 0, 4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 4'b0001);
      cycle(0, 1, 4'b0000);
    end
`ifdef COMBO_BONUS_EN
    exp_score = 12;
`else
    exp_score = 10;
`endif
    checks++;
    if ({score, combo, misses} !== {SW'(exp_score), 8'd10, 4'd0}) begin
      errors++; $display("FAIL ten_hits got score %0d combo %0d misses %0d exp %0d 10 0", score, combo, misses, exp_score);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 4'b0000);
    cycle(0, 1, 4'b0101);
    cycle(0, 1, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({track, pat_addr, score, stop, playing, done} !== {{(D*L+8+SW){1'b0}}, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got track %h addr %0d stop %b playing %b exp 0 0 1 0",
                         track, pat_addr, stop, playing);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    cycle(0, 1, 4'b0000);
    checks++;
    if ({track, playing, stop} !== {{(D*L){1'b0}}, 1'b0, 1'b1}) begin
      errors++; $display("FAIL post_reset_idle got track %h playing %b stop %b exp 0 0 1", track, playing, stop);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; pads = '0;
    for (int i = 0; i < 256; i++) pattern[i] = L'($urandom_range(0, 15) | $urandom_range(0, 15));
    pattern[0] = 4'b0001; pattern[1] = 4'b0001; pattern[2] = 4'b0010;
    pattern[3] = 4'b1010; pattern[4] = 4'b0000;
    test_reset();
    test_scroll_load();
    test_hit();
    test_miss_wrong();
    test_simultaneous();
    test_random_play(5000);
    test_end_of_song();
    test_combo_bonus();
    test_random_play(5000);
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/drum_note_scroller.md
Name: drum_note_scroller

Overview:
- Downstream consumer of the tempo tick stage (clk32) in the DrumsHeroe datapath.
- Each tick, the note track shifts one row toward the hit row.
- Judges drum-pad presses against the bottom row and keeps score, miss and combo counters.
- Drives the tick generator's stop input, so ticks only run while a song is playing.

Parameters:
- LANES, 4, number of drum lanes (pads).
- DEPTH, 16, rows in the visible track; row 0 is the hit row.
- SONG_LEN, 256, pattern rows per song; pat_addr counts 0..SONG_LEN-1.
- SCORE_W, 12, width of the score and misses counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a song.
- tick  in  1  one-cycle scroll pulse from the tempo generator (clk32).
- pads  in  LANES  debounced, clk-synchronous pad levels; 1 = pressed.
- pat_data  in  LANES  pattern row at pat_addr; combinational ROM read, valid in the same cycle.
- pat_addr  out  8  pattern row address.
- stop  out  1  high holds the tempo generator in reset.
- track  out  DEPTH*LANES  track contents; row r occupies bits [r*LANES +: LANES].
- score  out  SCORE_W  hit points, saturating.
- misses  out  SCORE_W  missed notes, saturating.
- combo  out  8  consecutive hits, saturating at 255.
- hit_pulse  out  1  one-cycle pulse when at least one hit is judged.
- miss_pulse  out  1  one-cycle pulse when at least one note is missed.
- playing  out  1  high in PLAY.
- done  out  1  high in DONE.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - track, score, misses, combo, pat_addr = 0.
  - Counters: load counter and flush counter = 0.
  - Outputs: stop = 1; hit_pulse, miss_pulse, playing, done = 0.
  - Pad history register = 0.
- FSM:
  - IDLE -> PLAY on start.
  - PLAY -> DONE when the flush completes.
  - DONE -> PLAY on start.
  - start in PLAY is ignored.
- Entering PLAY clears track, score, misses, combo, pat_addr and both counters in the same edge.
- stop = 1 in IDLE and DONE, 0 in PLAY. Registered, so it changes one cycle after the state change.
- Pad edges:
  - press[i] = pads[i] & ~pads_q[i]; pads_q is updated every cycle in all states.
  - Presses are judged only in PLAY.
- Judgement, each PLAY cycle, using row 0 before any shift:
  - Hit: press[i] and row0[i]. The note in row0[i] is cleared.
  - Wrong press: press[i] and !row0[i]. combo is cleared; score is unchanged.
  - Several lanes are judged independently in the same cycle.
  - score += popcount(hits).
  - combo += popcount(hits), unless a wrong press occurs in the same cycle; then combo = 0.
  - hit_pulse is registered, one cycle after the press.
- Scroll on tick in PLAY:
  - Row r takes row r+1.
  - Row DEPTH-1 takes pat_data while the load count < SONG_LEN, otherwise 0.
  - pat_addr increments after each load.
- Miss on scroll:
  - Notes still present in row 0 after judging in the same cycle are shifted out as misses.
  - misses += popcount; combo = 0; miss_pulse fires.
  - Same-cycle tick and press: the press is judged first, so a hit note is not counted as a miss.
- Flush: after SONG_LEN loads, DEPTH further ticks shift zeros in. On the last of these ticks, the FSM goes to DONE.
- Saturation: score and misses hold at 2^SCORE_W-1; combo holds at 255; no wrap-around.
- Ticks outside PLAY are ignored.
- An asynchronous reset mid-song returns the block to reset values immediately.

Optional Feature:
- Macro: COMBO_BONUS_EN.
- When defined: each hit judged while combo (before the update) >= 8 adds 2 points instead of 1.
- When undefined: every hit adds 1 point.
- Combo and miss logic are identical in both builds.

Test Plan:
- Reset then idle: release rst_n, drive no start -> stop=1, playing=0, score=0, track=0; 10 ticks leave track unchanged.
- Scroll and load: start, pat_data=4'b0001 on first load then 0, tick x16 -> lane0 note in row DEPTH-1 after the first tick, in row 0 after 16 ticks; pat_addr=16.
- Hit: with the note in row 0, press pads[0] for one cycle -> score=1, combo=1, hit_pulse high one cycle, row0 cleared; the next tick gives misses=0.
- Miss plus wrong press: the note reaches row 0 with no press, then tick -> misses=1, combo=0, miss_pulse high; a press on an empty lane -> combo=0, score unchanged.
- Simultaneous and multi-lane: row0=4'b1010, press pads 1 and 3 in the same cycle as a tick -> score += 2, misses += 0.
- End of song: SONG_LEN=4, tick 4+DEPTH times -> done=1, stop=1 one cycle later, further ticks ignored; start -> PLAY with counters cleared. With COMBO_BONUS_EN, 10 consecutive hits give score=1*8+2*2=12.
